// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants and write-buffer state encoding for the register write arbiter.
package reg_write_arbiter_pkg;

  localparam int unsigned DEF_WIDTH    = 16;
  localparam int unsigned DEF_NUM_REQ  = 4;
  localparam int unsigned DEF_NUM_REGS = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WRITE = 2'd1,
    ST_STALL = 2'd2
  } wr_state_e;

  // WRITE and STALL share the same stored "full" bit; the hold input picks between them.
  function automatic wr_state_e decode_state(input logic full, input logic hold);
    if (!full)     return ST_EMPTY;
    else if (hold) return ST_STALL;
    else           return ST_WRITE;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_arbiter.sv
// Round-robin one-hot grant: search starts at I_PTR and wraps modulo P_N.
module rr_arbiter #(
  parameter  int unsigned P_N = 4,
  localparam int unsigned PW  = (P_N > 1) ? $clog2(P_N) : 1
) (
  input  logic [P_N-1:0] I_REQ,
  input  logic [PW-1:0]  I_PTR,
  input  logic           I_EN,
  output logic [P_N-1:0] O_GRANT
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    O_GRANT = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned off = 0; off < P_N; off++) begin
      idx = PW'((32'(I_PTR) + off) % P_N);
      if (I_EN && !found && I_REQ[idx]) begin
        O_GRANT[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates requester writes into a one-entry buffer that drives a shared register write port.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter  int unsigned P_WIDTH    = DEF_WIDTH,
  parameter  int unsigned P_NUM_REQ  = DEF_NUM_REQ,
  parameter  int unsigned P_NUM_REGS = DEF_NUM_REGS,
  localparam int unsigned AW         = (P_NUM_REGS > 1) ? $clog2(P_NUM_REGS) : 1,
  localparam int unsigned GW         = $clog2(P_NUM_REQ)
) (
  input  logic                         I_CLK,
  input  logic                         I_NRESET,
  input  logic [P_NUM_REQ-1:0]         I_REQ_VALID,
  input  logic [P_NUM_REQ*AW-1:0]      I_REQ_ADDR,
  input  logic [P_NUM_REQ*P_WIDTH-1:0] I_REQ_DATA,
  input  logic                         I_HOLD,
  output logic [P_NUM_REQ-1:0]         O_REQ_READY,
  output logic [P_NUM_REGS-1:0]        O_WR_EN,
  output logic [P_WIDTH-1:0]           O_WR_DATA,
  output logic [GW-1:0]                O_GRANT_ID,
  output logic                         O_BUSY
);

  wr_state_e              state;
  logic                   full_q, full_d;
  logic [AW-1:0]          addr_q;
  logic [P_WIDTH-1:0]     data_q;
  logic [GW-1:0]          gid_q, ptr_q, ptr_d;
  logic                   accept, xfer;
  logic [P_NUM_REQ-1:0]   grant;
  logic [GW-1:0]          grant_idx;
  logic [AW-1:0]          sel_addr;
  logic [P_WIDTH-1:0]     sel_data;

  // Reset gates acceptance so no ready strobe escapes while held in reset.
  always_comb begin
    state  = decode_state(full_q, I_HOLD);
    accept = I_NRESET && (state != ST_STALL);
  end

  rr_arbiter #(.P_N(P_NUM_REQ)) u_rr (
    .I_REQ   (I_REQ_VALID),
    .I_PTR   (ptr_q),
    .I_EN    (accept),
    .O_GRANT (grant)
  );

  always_comb begin
    grant_idx = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int unsigned i = 0; i < P_NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = GW'(i);
        sel_addr  = I_REQ_ADDR[i*AW +: AW];
        sel_data  = I_REQ_DATA[i*P_WIDTH +: P_WIDTH];
      end
    end
    xfer  = |grant;
    ptr_d = (32'(grant_idx) == P_NUM_REQ - 1) ? '0 : grant_idx + GW'(1);
  end

  always_comb begin
    full_d  = full_q;
    O_WR_EN = '0;
    case (state)
      ST_EMPTY: full_d = xfer;
      ST_WRITE: begin
        full_d = xfer;
        // Out-of-range addresses match no register and simply drain.
        for (int unsigned r = 0; r < P_NUM_REGS; r++)
          O_WR_EN[r] = (addr_q == AW'(r));
      end
      ST_STALL: full_d = 1'b1;
      default:  full_d = 1'b0;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      gid_q  <= '0;
      ptr_q  <= '0;
    end else begin
      full_q <= full_d;
      if (xfer) begin
        addr_q <= sel_addr;
        data_q <= sel_data;
        gid_q  <= grant_idx;
        ptr_q  <= ptr_d;
      end
    end
  end

  assign O_REQ_READY = grant;
  assign O_WR_DATA   = data_q;
  assign O_GRANT_ID  = gid_q;
  assign O_BUSY      = full_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a local register file fed by the write port.
module tb_reg_write_arbiter;

  logic        I_CLK = 1'b0;
  logic        I_NRESET;
  logic [3:0]  I_REQ_VALID;
  logic [15:0] I_REQ_ADDR;
  logic [63:0] I_REQ_DATA;
  logic        I_HOLD;
  logic [3:0]  O_REQ_READY;
  logic [15:0] O_WR_EN;
  logic [15:0] O_WR_DATA;
  logic [1:0]  O_GRANT_ID;
  logic        O_BUSY;

  logic [15:0] regs [16];
  int total = 0;
  int bad   = 0;

  reg_write_arbiter #(.P_WIDTH(16), .P_NUM_REQ(4), .P_NUM_REGS(16)) dut (
    .I_CLK(I_CLK), .I_NRESET(I_NRESET), .I_REQ_VALID(I_REQ_VALID),
    .I_REQ_ADDR(I_REQ_ADDR), .I_REQ_DATA(I_REQ_DATA), .I_HOLD(I_HOLD),
    .O_REQ_READY(O_REQ_READY), .O_WR_EN(O_WR_EN), .O_WR_DATA(O_WR_DATA),
    .O_GRANT_ID(O_GRANT_ID), .O_BUSY(O_BUSY)
  );

  always #5 I_CLK = ~I_CLK;

  always @(posedge I_CLK)
    for (int r = 0; r < 16; r++)
      if (O_WR_EN[r]) regs[r] <= O_WR_DATA;

  always @(negedge I_CLK) begin
    total++;
    if (!$onehot0(O_WR_EN) || !$onehot0(O_REQ_READY)) begin
      bad++;
      $display("FAIL onehot wr_en=%h ready=%b", O_WR_EN, O_REQ_READY);
    end
  end

  task automatic step();
    @(posedge I_CLK);
    #2;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] a, input logic [15:0] d);
    I_REQ_VALID[i]        = v;
    I_REQ_ADDR[i*4 +: 4]  = a;
    I_REQ_DATA[i*16 +: 16] = d;
  endtask

  task automatic test_reset();
    I_NRESET = 1'b0; I_HOLD = 1'b0;
    I_REQ_VALID = 4'hF; I_REQ_ADDR = '0; I_REQ_DATA = '0;
    #1;
    total++; if (O_REQ_READY !== 4'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0000", O_REQ_READY); end
    total++; if (O_WR_EN !== 16'h0) begin bad++; $display("FAIL rst_wr_en got=%h exp=0000", O_WR_EN); end
    total++; if (O_WR_DATA !== 16'h0) begin bad++; $display("FAIL rst_data got=%h exp=0000", O_WR_DATA); end
    total++; if (O_BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", O_BUSY); end
    total++; if (O_GRANT_ID !== 2'd0) begin bad++; $display("FAIL rst_gid got=%0d exp=0", O_GRANT_ID); end
    I_REQ_VALID = '0;
    step(); step();
    I_NRESET = 1'b1;
  endtask

  task automatic test_single();
    set_req(2, 1'b1, 4'd5, 16'hBEEF);
    #1;
    total++; if (O_REQ_READY !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b exp=0100", O_REQ_READY); end
    step();
    set_req(2, 1'b0, 4'd0, 16'h0);
    #1;
    total++; if (O_WR_EN !== 16'h0020) begin bad++; $display("FAIL single_wr_en got=%h exp=0020", O_WR_EN); end
    total++; if (O_WR_DATA !== 16'hBEEF) begin bad++; $display("FAIL single_data got=%h exp=beef", O_WR_DATA); end
    total++; if (O_BUSY !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", O_BUSY); end
    total++; if (O_GRANT_ID !== 2'd2) begin bad++; $display("FAIL single_gid got=%0d exp=2", O_GRANT_ID); end
    step();
    #1;
    total++; if (O_WR_EN !== 16'h0) begin bad++; $display("FAIL single_drain got=%h exp=0000", O_WR_EN); end
    total++; if (O_BUSY !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", O_BUSY); end
    total++; if (O_WR_DATA !== 16'hBEEF) begin bad++; $display("FAIL single_hold_data got=%h exp=beef", O_WR_DATA); end
    total++; if (regs[5] !== 16'hBEEF) begin bad++; $display("FAIL single_reg5 got=%h exp=beef", regs[5]); end
  endtask

  task automatic test_back_to_back();
    step();
    I_NRESET = 1'b0;
    step();
    I_NRESET = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'(8 + i), 16'hA000 + 16'(i));
    for (int k = 0; k < 5; k++) begin
      int g = k % 4;
      #1;
      total++; if (O_REQ_READY !== (4'b1 << g)) begin bad++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, O_REQ_READY, 4'b1 << g); end
      step();
      #1;
      total++; if (O_GRANT_ID !== 2'(g)) begin bad++; $display("FAIL b2b_gid k=%0d got=%0d exp=%0d", k, O_GRANT_ID, g); end
      total++; if (O_WR_EN !== (16'h1 << (8 + g))) begin bad++; $display("FAIL b2b_wr_en k=%0d got=%h exp=%h", k, O_WR_EN, 16'h1 << (8 + g)); end
      total++; if (O_WR_DATA !== 16'hA000 + 16'(g)) begin bad++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, O_WR_DATA, 16'hA000 + 16'(g)); end
    end
    I_REQ_VALID = '0;
    step();
    #1;
    total++; if (O_BUSY !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", O_BUSY); end
    for (int i = 0; i < 4; i++) begin
      total++; if (regs[8+i] !== 16'hA000 + 16'(i)) begin bad++; $display("FAIL b2b_reg%0d got=%h exp=%h", 8 + i, regs[8+i], 16'hA000 + 16'(i)); end
    end
  endtask

  task automatic test_hold();
    set_req(0, 1'b1, 4'd3, 16'h1234);
    #1;
    total++; if (O_REQ_READY !== 4'b0001) begin bad++; $display("FAIL hold_ready0 got=%b exp=0001", O_REQ_READY); end
    step();
    set_req(0, 1'b0, 4'd0, 16'h0);
    set_req(1, 1'b1, 4'd4, 16'h5555);
    I_HOLD = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (O_WR_EN !== 16'h0) begin bad++; $display("FAIL hold_wr_en c=%0d got=%h exp=0000", c, O_WR_EN); end
      total++; if (O_REQ_READY !== 4'b0) begin bad++; $display("FAIL hold_ready c=%0d got=%b exp=0000", c, O_REQ_READY); end
      total++; if (O_BUSY !== 1'b1) begin bad++; $display("FAIL hold_busy c=%0d got=%b exp=1", c, O_BUSY); end
      step();
    end
    set_req(1, 1'b0, 4'd0, 16'h0);
    I_HOLD = 1'b0;
    #1;
    total++; if (O_WR_EN !== 16'h0008) begin bad++; $display("FAIL hold_release got=%h exp=0008", O_WR_EN); end
    total++; if (O_WR_DATA !== 16'h1234) begin bad++; $display("FAIL hold_data got=%h exp=1234", O_WR_DATA); end
    total++; if (O_GRANT_ID !== 2'd0) begin bad++; $display("FAIL hold_gid got=%0d exp=0", O_GRANT_ID); end
    step();
    #1;
    total++; if (regs[3] !== 16'h1234) begin bad++; $display("FAIL hold_reg3 got=%h exp=1234", regs[3]); end
    total++; if (O_BUSY !== 1'b0) begin bad++; $display("FAIL hold_idle got=%b exp=0", O_BUSY); end
  endtask

  task automatic test_pointer();
    set_req(1, 1'b1, 4'd0, 16'h0101);
    step();
    set_req(1, 1'b0, 4'd0, 16'h0);
    step();
    set_req(1, 1'b1, 4'd1, 16'h0111);
    set_req(3, 1'b1, 4'd2, 16'h0333);
    #1;
    total++; if (O_REQ_READY !== 4'b1000) begin bad++; $display("FAIL ptr_ready3 got=%b exp=1000", O_REQ_READY); end
    step();
    #1;
    total++; if (O_GRANT_ID !== 2'd3) begin bad++; $display("FAIL ptr_gid3 got=%0d exp=3", O_GRANT_ID); end
    total++; if (O_WR_EN !== 16'h0004) begin bad++; $display("FAIL ptr_wr_en3 got=%h exp=0004", O_WR_EN); end
    total++; if (O_REQ_READY !== 4'b0010) begin bad++; $display("FAIL ptr_ready1 got=%b exp=0010", O_REQ_READY); end
    step();
    #1;
    total++; if (O_GRANT_ID !== 2'd1) begin bad++; $display("FAIL ptr_gid1 got=%0d exp=1", O_GRANT_ID); end
    total++; if (O_WR_EN !== 16'h0002) begin bad++; $display("FAIL ptr_wr_en1 got=%h exp=0002", O_WR_EN); end
    total++; if (O_WR_DATA !== 16'h0111) begin bad++; $display("FAIL ptr_data1 got=%h exp=0111", O_WR_DATA); end
    I_REQ_VALID = '0;
    step();
    #1;
    total++; if (regs[2] !== 16'h0333) begin bad++; $display("FAIL ptr_reg2 got=%h exp=0333", regs[2]); end
    total++; if (regs[1] !== 16'h0111) begin bad++; $display("FAIL ptr_reg1 got=%h exp=0111", regs[1]); end
  endtask

  task automatic test_reset_mid();
    set_req(0, 1'b1, 4'd7, 16'h1111);
    #1;
    total++; if (O_REQ_READY !== 4'b0001) begin bad++; $display("FAIL mid_ready got=%b exp=0001", O_REQ_READY); end
    step();
    set_req(0, 1'b0, 4'd0, 16'h0);
    step();
    #1;
    total++; if (regs[7] !== 16'h1111) begin bad++; $display("FAIL mid_reg7_pre got=%h exp=1111", regs[7]); end
    set_req(0, 1'b1, 4'd7, 16'h7777);
    step();
    set_req(0, 1'b0, 4'd0, 16'h0);
    #1;
    total++; if (O_WR_EN !== 16'h0080) begin bad++; $display("FAIL mid_wr_en_pre got=%h exp=0080", O_WR_EN); end
    I_NRESET = 1'b0;
    #1;
    total++; if (O_WR_EN !== 16'h0) begin bad++; $display("FAIL mid_wr_en got=%h exp=0000", O_WR_EN); end
    total++; if (O_BUSY !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", O_BUSY); end
    total++; if (O_WR_DATA !== 16'h0) begin bad++; $display("FAIL mid_data got=%h exp=0000", O_WR_DATA); end
    step();
    #1;
    total++; if (regs[7] !== 16'h1111) begin bad++; $display("FAIL mid_reg7 got=%h exp=1111", regs[7]); end
    I_NRESET = 1'b1;
    set_req(0, 1'b1, 4'd9, 16'h0009);
    set_req(3, 1'b1, 4'd10, 16'h000A);
    #1;
    total++; if (O_REQ_READY !== 4'b0001) begin bad++; $display("FAIL mid_ptr0 got=%b exp=0001", O_REQ_READY); end
    step();
    #1;
    total++; if (O_GRANT_ID !== 2'd0) begin bad++; $display("FAIL mid_gid got=%0d exp=0", O_GRANT_ID); end
    total++; if (O_WR_EN !== 16'h0200) begin bad++; $display("FAIL mid_wr_en_post got=%h exp=0200", O_WR_EN); end
    I_REQ_VALID = '0;
    step();
    #1;
    total++; if (regs[9] !== 16'h0009) begin bad++; $display("FAIL mid_reg9 got=%h exp=0009", regs[9]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_pointer();
    test_reset_mid();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
